door_input_conditioner: RTL and testbench

DOOR_INPUT_CONDITIONER -- requirements
Module: door_input_conditioner

---
 rtl/door_input_conditioner_pkg.sv | 21 ++
 rtl/door_input_conditioner_debounce_cell.sv | 43 ++++
 rtl/door_input_conditioner.sv | 86 ++++++++
 tb/tb_door_input_conditioner.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/door_input_conditioner_pkg.sv
// Shared definitions for the door input conditioner and the door motor bench:
// button FSM state encodings, channel indices and default timing values.
package door_input_conditioner_pkg;

   localparam int DEF_DEBOUNCE_CYCLES = 16;
   localparam int DEF_HOLDOFF_CYCLES  = 64;

   // Channel positions in the packed raw/debounced vectors.
   localparam int CH_BTN = 0;
   localparam int CH_UP  = 1;
   localparam int CH_DN  = 2;
   localparam int NUM_CH = 3;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_PULSE    = 2'd1,
      ST_WAIT_REL = 2'd2,
      ST_HOLDOFF  = 2'd3
   } btn_state_t;

endpackage

// File: rtl/door_input_conditioner_debounce_cell.sv
// One input channel: 2-flop synchroniser feeding a stable-level debouncer.
// The level flips only after DEBOUNCE_CYCLES consecutive synchronised samples
// that differ from it; any agreeing sample restarts the count.
module debounce_cell #(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic level
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [1:0]       sync_q;
   logic [CNT_W-1:0] cnt;
   logic             stable;

   // Bring the asynchronous input into the clk domain.
   always_ff @(posedge clk) begin
      if (!rst) sync_q <= '0;
      else      sync_q <= {sync_q[0], raw};
   end

   // Count consecutive disagreeing samples; flip the level on the last one.
   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt    <= '0;
         stable <= 1'b0;
      end else if (sync_q[1] == stable) begin
         cnt <= '0;
      end else if (cnt == CNT_LAST) begin
         cnt    <= '0;
         stable <= ~stable;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   assign level = stable;

endmodule

// File: rtl/door_input_conditioner.sv
// Conditions the door push-button and the two limit switches for the motor
// FSM: debounced limit levels, a registered both-limits fault flag, and a
// single activate pulse per qualified button press followed by a holdoff.
module door_input_conditioner
   import door_input_conditioner_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int HOLDOFF_CYCLES  = DEF_HOLDOFF_CYCLES
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_raw,
   input  logic up_lim_raw,
   input  logic dn_lim_raw,
   output logic activate,
   output logic up_max,
   output logic dn_max,
   output logic lim_fault
);

   localparam int HO_W = $clog2(HOLDOFF_CYCLES + 1);
   localparam logic [HO_W-1:0] HO_LAST = HO_W'(HOLDOFF_CYCLES - 1);

   logic [NUM_CH-1:0] raw_vec;
   logic [NUM_CH-1:0] lvl_vec;
   logic              btn_db;
   logic              fault_q;
   logic [HO_W-1:0]   ho_cnt;
   btn_state_t        state, state_nxt;

   assign raw_vec[CH_BTN] = btn_raw;
   assign raw_vec[CH_UP]  = up_lim_raw;
   assign raw_vec[CH_DN]  = dn_lim_raw;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      debounce_cell #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_db (
         .clk  (clk),
         .rst  (rst),
         .raw  (raw_vec[i]),
         .level(lvl_vec[i])
      );
   end

   assign btn_db = lvl_vec[CH_BTN];
   assign up_max = lvl_vec[CH_UP];
   assign dn_max = lvl_vec[CH_DN];

   // Both limits active at once is a wiring/switch fault; register it.
   always_ff @(posedge clk) begin
      if (!rst) fault_q <= 1'b0;
      else      fault_q <= lvl_vec[CH_UP] & lvl_vec[CH_DN];
   end

   assign lim_fault = fault_q;

   // Button FSM state register.
   always_ff @(posedge clk) begin
      if (!rst) state <= ST_IDLE;
      else      state <= state_nxt;
   end

   // Holdoff counter runs only while in HOLDOFF, cleared everywhere else.
   always_ff @(posedge clk) begin
      if (!rst)                    ho_cnt <= '0;
      else if (state != ST_HOLDOFF) ho_cnt <= '0;
      else                         ho_cnt <= ho_cnt + 1'b1;
   end

   // Next-state logic: one pulse per press, wait for release, then holdoff.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:     if (btn_db && !fault_q) state_nxt = ST_PULSE;
         ST_PULSE:    state_nxt = ST_WAIT_REL;
         ST_WAIT_REL: if (!btn_db) state_nxt = ST_HOLDOFF;
         ST_HOLDOFF:  if (ho_cnt == HO_LAST) state_nxt = ST_IDLE;
         default:     state_nxt = ST_IDLE;
      endcase
   end

   // Moore output decoded from the state flops only.
   assign activate = (state == ST_PULSE);

endmodule

// File: tb/tb_door_input_conditioner.sv
// Directed bench for door_input_conditioner with DEBOUNCE_CYCLES=4 and
// HOLDOFF_CYCLES=8. Inputs change 1 time unit after a rising edge; outputs
// are sampled at the same point, so "tick n" below is the state after the
// n-th edge since the input change.
module tb_door_input_conditioner;

   logic clk = 1'b0;
   logic rst;
   logic btn_raw, up_lim_raw, dn_lim_raw;
   logic activate, up_max, dn_max, lim_fault;

   int n_cmp = 0;
   int n_err = 0;

   door_input_conditioner #(
      .DEBOUNCE_CYCLES(4),
      .HOLDOFF_CYCLES (8)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .btn_raw   (btn_raw),
      .up_lim_raw(up_lim_raw),
      .dn_lim_raw(dn_lim_raw),
      .activate  (activate),
      .up_max    (up_max),
      .dn_max    (dn_max),
      .lim_fault (lim_fault)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
      end
   endtask

   // Run n ticks checking activate each tick; it must be 1 only at tick pulse_at
   // (pulse_at = 0 means no pulse allowed).
   task automatic run_act(input string tag, input int n, input int pulse_at);
      for (int i = 1; i <= n; i++) begin
         tick();
         chk($sformatf("%s_act_t%0d", tag, i), activate, (i == pulse_at));
      end
   endtask

   initial begin
      rst = 1'b0; btn_raw = 1'b0; up_lim_raw = 1'b0; dn_lim_raw = 1'b0;
      tick(); tick();
      chk("rst_activate", activate, 1'b0);
      chk("rst_up_max", up_max, 1'b0);
      chk("rst_dn_max", dn_max, 1'b0);
      chk("rst_lim_fault", lim_fault, 1'b0);
      rst = 1'b1;
      tick(); tick();

      // Single long press: debounced at tick 6, PULSE at tick 7, nothing else.
      btn_raw = 1'b1;
      run_act("press40", 40, 7);
      btn_raw = 1'b0;
      run_act("rel40", 20, 0);

      // Bounce every 2 cycles never survives a 4-cycle debounce.
      for (int j = 0; j < 5; j++) begin
         btn_raw = 1'b1; run_act("bounce_hi", 2, 0);
         btn_raw = 1'b0; run_act("bounce_lo", 2, 0);
      end
      run_act("bounce_tail", 10, 0);

      // Lower limit, then upper limit: fault one tick after both levels set.
      dn_lim_raw = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         tick();
         chk($sformatf("dn_max_t%0d", i), dn_max, (i >= 6));
      end
      up_lim_raw = 1'b1;
      for (int i = 1; i <= 7; i++) begin
         tick();
         chk($sformatf("up_max_t%0d", i), up_max, (i >= 6));
         chk($sformatf("flt_t%0d", i), lim_fault, (i >= 7));
      end
      // Press under fault: blocked.
      btn_raw = 1'b1;
      run_act("press_fault", 15, 0);
      // Clear upper limit while held: fault drops at tick 7, PULSE at tick 8.
      up_lim_raw = 1'b0;
      for (int i = 1; i <= 10; i++) begin
         tick();
         chk($sformatf("clr_flt_t%0d", i), lim_fault, (i < 7));
         chk($sformatf("clr_act_t%0d", i), activate, (i == 8));
      end
      btn_raw = 1'b0; dn_lim_raw = 1'b0;
      run_act("clr_rel", 30, 0);

      // Re-press 1 cycle into HOLDOFF: ignored until IDLE at R+15, PULSE R+16.
      btn_raw = 1'b1;
      run_act("hoA_p1", 10, 7);
      btn_raw = 1'b0;
      run_act("hoA_rel", 8, 0);
      btn_raw = 1'b1;
      run_act("hoA_p2", 20, 8);
      btn_raw = 1'b0;
      run_act("hoA_end", 30, 0);

      // Re-press 3 cycles after WAIT_REL exit: PULSE at R+17.
      btn_raw = 1'b1;
      run_act("hoB_p1", 10, 7);
      btn_raw = 1'b0;
      run_act("hoB_rel", 10, 0);
      btn_raw = 1'b1;
      run_act("hoB_p2", 20, 7);
      btn_raw = 1'b0;
      run_act("hoB_end", 30, 0);

      // Reset mid-debounce with limits latched: everything clears, and the
      // still-held button takes the full latency again.
      up_lim_raw = 1'b1; dn_lim_raw = 1'b1;
      for (int i = 1; i <= 8; i++) tick();
      chk("pre_rst_flt", lim_fault, 1'b1);
      chk("pre_rst_up", up_max, 1'b1);
      up_lim_raw = 1'b0; dn_lim_raw = 1'b0; btn_raw = 1'b1;
      tick(); tick(); tick();
      rst = 1'b0;
      tick();
      chk("mid_rst_activate", activate, 1'b0);
      chk("mid_rst_up_max", up_max, 1'b0);
      chk("mid_rst_dn_max", dn_max, 1'b0);
      chk("mid_rst_lim_fault", lim_fault, 1'b0);
      rst = 1'b1;
      run_act("post_rst", 12, 7);
      btn_raw = 1'b0;
      run_act("post_rst_rel", 20, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
